// File: rtl/pwm_audio_pkg.sv
// Shared types and helpers for the PWM audio decoder.
//   act_state_e      : activity state (SILENT / ACTIVE)
//   *_DEF            : default parameter values for the decoder
//   sat_inc()        : increment that sticks at a ceiling instead of wrapping
package pwm_audio_pkg;

  typedef enum logic {
    SILENT = 1'b0,
    ACTIVE = 1'b1
  } act_state_e;

  localparam int unsigned WINDOW_BITS_DEF    = 16;
  localparam int unsigned EDGE_BITS_DEF      = 12;
  localparam int unsigned SILENCE_FRAMES_DEF = 4;

  // Adds i_inc to i_val, holding at i_max once reached.
  function automatic logic [31:0] sat_inc(input logic [31:0] i_val, input logic i_inc,
                                          input logic [31:0] i_max);
    if (i_inc && (i_val < i_max)) begin
      return i_val + 32'd1;
    end
    return i_val;
  endfunction

endpackage

// File: rtl/pwm_window_timer.sv
// Free-running power-of-two window timer for windowed monitors.
//   i_clk          : clock
//   i_reset        : synchronous active-high reset
//   i_enable       : run; low holds the counter at 0 so a fresh window starts on re-enable
//   o_window_end   : high on the last cycle of each window (counter all-ones, enabled)
module pwm_window_timer #(
  parameter int unsigned WINDOW_BITS = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_enable,
  output logic o_window_end
);

  logic [WINDOW_BITS-1:0] r_wc;

  always_ff @(posedge i_clk) begin
    if (i_reset || !i_enable) begin
      r_wc <= '0;
    end else begin
      r_wc <= r_wc + 1'b1;
    end
  end

  assign o_window_end = i_enable && (&r_wc);

endmodule

// File: rtl/pwm_audio_decoder.sv
// Recovers a duty-cycle sample and rising-edge count from the APU 1-bit PWM stream over a
// fixed 2^WINDOW_BITS clock window, and tracks whether audio is active.
//   i_clk          : system clock
//   i_reset        : synchronous active-high reset
//   i_enable       : decoder run; low discards the current window and forces SILENT
//   i_sound        : PWM audio stream
//   o_sample       : high-cycle count of the last window, saturating at 2^WINDOW_BITS-1
//   o_sample_sat   : last window was high on every cycle (count 2^WINDOW_BITS)
//   o_edge_count   : rising edges in the last window, saturating at all-ones
//   o_sample_valid : one-cycle strobe when the outputs above and o_active update
//   o_active       : activity state, 1 = ACTIVE
module pwm_audio_decoder
  import pwm_audio_pkg::*;
#(
  parameter int unsigned WINDOW_BITS    = WINDOW_BITS_DEF,
  parameter int unsigned EDGE_BITS      = EDGE_BITS_DEF,
  parameter int unsigned SILENCE_FRAMES = SILENCE_FRAMES_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic                   i_sound,
  output logic [WINDOW_BITS-1:0] o_sample,
  output logic                   o_sample_sat,
  output logic [EDGE_BITS-1:0]   o_edge_count,
  output logic                   o_sample_valid,
  output logic                   o_active
);

  localparam logic [31:0] EDGE_MAX = 32'((64'd1 << EDGE_BITS) - 64'd1);
  localparam logic [7:0]  QUIET_LIMIT = 8'(SILENCE_FRAMES);
  // Only reachable when every cycle of the window was high.
  localparam logic [WINDOW_BITS:0] TOTAL_FULL = {1'b1, {WINDOW_BITS{1'b0}}};

  logic                   r_sound_q;
  logic                   r_sound_prev;
  logic [WINDOW_BITS:0]   r_acc;
  logic [EDGE_BITS-1:0]   r_edge_acc;
  logic [7:0]             r_quiet;
  act_state_e             r_state;
  logic [WINDOW_BITS-1:0] r_sample;
  logic                   r_sample_sat;
  logic [EDGE_BITS-1:0]   r_edge_count;
  logic                   r_sample_valid;
  logic                   r_active;

  logic                   w_window_end;
  logic                   w_rise;
  logic [WINDOW_BITS:0]   w_total;
  logic [EDGE_BITS-1:0]   w_edge_total;
  logic [7:0]             w_quiet_inc;

  pwm_window_timer #(
    .WINDOW_BITS (WINDOW_BITS)
  ) u_timer (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_enable     (i_enable),
    .o_window_end (w_window_end)
  );

  assign w_rise       = r_sound_q & ~r_sound_prev;
  // Totals include the current cycle so the last window cycle is not lost.
  assign w_total      = r_acc + {{WINDOW_BITS{1'b0}}, r_sound_q};
  assign w_edge_total = EDGE_BITS'(sat_inc(32'(r_edge_acc), w_rise, EDGE_MAX));
  assign w_quiet_inc  = r_quiet + 8'd1;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sound_q      <= 1'b0;
      r_sound_prev   <= 1'b0;
      r_acc          <= '0;
      r_edge_acc     <= '0;
      r_quiet        <= '0;
      r_state        <= SILENT;
      r_sample       <= '0;
      r_sample_sat   <= 1'b0;
      r_edge_count   <= '0;
      r_sample_valid <= 1'b0;
      r_active       <= 1'b0;
    end else begin
      r_sound_q      <= i_sound;
      r_sample_valid <= 1'b0;
      if (!i_enable) begin
        // Partial window is discarded; published sample fields hold.
        r_sound_prev <= 1'b0;
        r_acc        <= '0;
        r_edge_acc   <= '0;
        r_quiet      <= '0;
        r_state      <= SILENT;
        r_active     <= 1'b0;
      end else begin
        r_sound_prev <= r_sound_q;
        if (w_window_end) begin
          r_sample       <= w_total[WINDOW_BITS] ? {WINDOW_BITS{1'b1}} : w_total[WINDOW_BITS-1:0];
          r_sample_sat   <= (w_total == TOTAL_FULL);
          r_edge_count   <= w_edge_total;
          r_sample_valid <= 1'b1;
          r_acc          <= '0;
          r_edge_acc     <= '0;
          if (w_total != '0) begin
            r_state  <= ACTIVE;
            r_active <= 1'b1;
            r_quiet  <= '0;
          end else if (r_state == ACTIVE) begin
            if (w_quiet_inc >= QUIET_LIMIT) begin
              r_state  <= SILENT;
              r_active <= 1'b0;
              r_quiet  <= '0;
            end else begin
              r_quiet  <= w_quiet_inc;
              r_active <= 1'b1;
            end
          end else begin
            r_quiet  <= '0;
            r_active <= 1'b0;
          end
        end else begin
          r_acc      <= w_total;
          r_edge_acc <= w_edge_total;
        end
      end
    end
  end

  assign o_sample       = r_sample;
  assign o_sample_sat   = r_sample_sat;
  assign o_edge_count   = r_edge_count;
  assign o_sample_valid = r_sample_valid;
  assign o_active       = r_active;

endmodule
